// File: rtl/neuron_synapse_mac.sv
// neuron_synapse_mac: three-synapse bit-serial weighted-sample MAC feeding the fire stage; optional NEURON_WEIGHT_LOCK_EN blocks mid-frame weight writes and flags them on wr_err
module neuron_synapse_mac #(
    parameter int IN_W     = 16,
    parameter int WEIGHT_W = 16,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic                wr_en,
    input  logic [1:0]          wr_addr,
    input  logic [WEIGHT_W-1:0] wr_data,
    output logic [DATA_W-1:0]   D1,
    output logic [DATA_W-1:0]   D2,
    output logic [DATA_W-1:0]   D3,
    output logic                out_valid
`ifdef NEURON_WEIGHT_LOCK_EN
    ,
    output logic                wr_err
`endif
);
    localparam int CW = (WEIGHT_W > 1) ? $clog2(WEIGHT_W) : 1;
    typedef enum logic [1:0] {IDLE, MUL, STORE} state_t;
    state_t state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0] smp_q, smp_d;
    logic [WEIGHT_W-1:0] wcur_q, wcur_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [WEIGHT_W-1:0] w_q [3];
    logic [WEIGHT_W-1:0] w_d [3];
    logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic ov_q, ov_d, wr_ok;
`ifdef NEURON_WEIGHT_LOCK_EN
    logic err_q, err_d;
    assign wr_err = err_q;
`endif
    assign in_ready  = (state_q == IDLE) && !rst;
    assign D1        = d1_q;
    assign D2        = d2_q;
    assign D3        = d3_q;
    assign out_valid = ov_q;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        smp_d   = smp_q;
        wcur_d  = wcur_q;
        acc_d   = acc_q;
        w_d     = w_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        ov_d    = 1'b0;
`ifdef NEURON_WEIGHT_LOCK_EN
        wr_ok   = (idx_q == 2'd0) && (state_q == IDLE);
        err_d   = wr_en && (wr_addr != 2'd3) && !wr_ok;
`else
        wr_ok   = 1'b1;
`endif
        for (int i = 0; i < 3; i++)
            if (wr_en && wr_ok && wr_addr == 2'(i)) w_d[i] = wr_data;
        // the accept reads w_q, so a same-edge write only reaches later samples
        if (state_q == IDLE && in_valid && in_ready) begin
            state_d = MUL;
            smp_d   = in_data;
            wcur_d  = w_q[idx_q];
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == MUL) begin
            acc_d   = acc_q + (wcur_q[cnt_q] ? (DATA_W'(smp_q) << cnt_q) : '0);
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WEIGHT_W - 1)) ? STORE : MUL;
        end else if (state_q == STORE) begin
            state_d = IDLE;
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            sh0_d   = (idx_q == 2'd0) ? acc_q : sh0_q;
            sh1_d   = (idx_q == 2'd1) ? acc_q : sh1_q;
            if (idx_q == 2'd2) begin
                d1_d = sh0_q;
                d2_d = sh1_q;
                d3_d = acc_q;
                ov_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            smp_q   <= '0;
            wcur_q  <= '0;
            acc_q   <= '0;
            w_q     <= '{default: '0};
            sh0_q   <= '0;
            sh1_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            ov_q    <= 1'b0;
`ifdef NEURON_WEIGHT_LOCK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            smp_q   <= smp_d;
            wcur_q  <= wcur_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            ov_q    <= ov_d;
`ifdef NEURON_WEIGHT_LOCK_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_neuron_synapse_mac.sv
// tb_neuron_synapse_mac: directed and random frames against a product-per-sample reference model
module tb_neuron_synapse_mac;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, wr_en = 1'b0;
    logic in_ready, out_valid;
    logic [15:0] in_data = '0, wr_data = '0;
    logic [1:0] wr_addr = '0;
    logic [31:0] D1, D2, D3;
`ifdef NEURON_WEIGHT_LOCK_EN
    logic wr_err;
`endif
    int checks = 0, errors = 0, cyc = 0, midx = 0;
    logic [15:0] mw [3] = '{default: '0};
    longint q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_synapse_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .D1(D1), .D2(D2), .D3(D3), .out_valid(out_valid)
`ifdef NEURON_WEIGHT_LOCK_EN
        , .wr_err(wr_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [15:0] s);
        q.push_back(longint'(s) * longint'(mw[midx]));
        midx = (midx + 1) % 3;
    endtask

    task automatic write_w(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < 2'd3) mw[a] = d;
`ifdef NEURON_WEIGHT_LOCK_EN
        chk("wr_err_idle", 64'(wr_err), 0);
`endif
    endtask

    task automatic send(input logic [15:0] s, input bit keep, output int t);
        int n = 0;
        in_valid = 1'b1; in_data = s;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (!in_ready) begin errors++; $error("FAIL ready_timeout observed 0 expected 1"); end
        tick();
        t = cyc;
        model_accept(s);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(input int t);
        int n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        chk("out_valid_seen", 64'(out_valid), 1);
        chk("latency", longint'(cyc - t), 17);
        chk("D1", 64'(D1), q.size() > 0 ? q[0] : -1);
        chk("D2", 64'(D2), q.size() > 1 ? q[1] : -1);
        chk("D3", 64'(D3), q.size() > 2 ? q[2] : -1);
        q.delete();
        tick();
        chk("strobe_len", 64'(out_valid), 0);
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input bit keep);
        int t0, t1, t2;
        send(a, keep, t0);
        send(b, keep, t1);
        send(c, 1'b0, t2);
        if (keep) begin
            chk("gap01", longint'(t1 - t0), 18);
            chk("gap12", longint'(t2 - t1), 18);
        end
        wait_out(t2);
    endtask

    initial begin
        int t;
        bit seen;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_D1", 64'(D1), 0);
        chk("rst_D2", 64'(D2), 0);
        chk("rst_D3", 64'(D3), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 1);

        write_w(0, 1); write_w(1, 2); write_w(2, 3);
        frame(1, 1, 1, 1'b0);
        chk("no_fire", longint'(D1) + longint'(D2) + longint'(D3) > 9, 0);
        frame(2, 2, 2, 1'b0);
        chk("fire", longint'(D1) + longint'(D2) + longint'(D3) > 9, 1);

        write_w(0, 16'hFFFF); write_w(1, 16'hFFFF); write_w(2, 16'hFFFF);
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        chk("max_D3", 64'(D3), 64'h0FFFE0001);

        write_w(0, 1); write_w(1, 1); write_w(2, 1);
        frame(5, 6, 7, 1'b1);

        write_w(0, 3); write_w(1, 3); write_w(2, 3);
        send(4, 1'b0, t);
        repeat (4) tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd10;
        tick();
        wr_en = 1'b0;
`ifdef NEURON_WEIGHT_LOCK_EN
        chk("wr_err_pulse", 64'(wr_err), 1);
        tick();
        chk("wr_err_clear", 64'(wr_err), 0);
`else
        mw[0] = 16'd10;
`endif
        send(1, 1'b0, t);
        send(1, 1'b0, t);
        wait_out(t);
        frame(4, 1, 1, 1'b0);

        write_w(0, 1);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd9;
        in_valid = 1'b1; in_data = 16'd2;
        chk("simul_ready", 64'(in_ready), 1);
        tick();
        wr_en = 1'b0; in_valid = 1'b0;
        model_accept(2);
        mw[0] = 16'd9;
        send(1, 1'b0, t);
        send(1, 1'b0, t);
        wait_out(t);
        frame(1, 1, 1, 1'b0);

        write_w(0, 1); write_w(1, 2); write_w(2, 3);
        frame(1, 1, 1, 1'b0);
        send(1, 1'b0, t);
        send(1, 1'b0, t);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 0);
        tick();
        rst = 1'b0;
        q.delete(); midx = 0; mw = '{default: '0};
        chk("midrst_D1", 64'(D1), 0);
        chk("midrst_D2", 64'(D2), 0);
        chk("midrst_D3", 64'(D3), 0);
        seen = 1'b0;
        repeat (40) begin tick(); seen |= out_valid; end
        chk("midrst_no_ov", 64'(seen), 0);
        write_w(0, 1); write_w(1, 2); write_w(2, 3);
        frame(2, 2, 2, 1'b0);

        for (int f = 0; f < 6; f++) begin
            write_w(2'd3, 16'($urandom));
            for (int k = 0; k < 3; k++) write_w(2'(k), 16'($urandom));
            frame(16'($urandom), 16'($urandom), 16'($urandom), f[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
